// File: rtl/sd_pkg.sv
// Shared definitions for the SD-card port arbiter: FSM state encoding,
// sector geometry and the address alignment helper.
package sd_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      BUSY  = 2'd2,
      DONE  = 2'd3
   } sd_arb_state_t;

   localparam int unsigned SD_SECTOR_BYTES = 512;
   localparam logic [31:0] SD_ALIGN_MASK   = 32'h1FF;

   // A sector address is usable only when it sits on a 512-byte boundary.
   function automatic logic sd_is_aligned(input logic [31:0] addr);
      return (addr & SD_ALIGN_MASK) == 32'd0;
   endfunction

endpackage

// File: rtl/sd_rr_pick.sv
// Two-way round-robin picker. On contention the port that was not served
// last wins; a lone requester always wins.
module sd_rr_pick (
   input  logic [1:0] req,
   input  logic       last,
   output logic       valid,
   output logic       sel
);

   // Purely combinational choice between the two requesters.
   always_comb begin
      valid = |req;
      sel   = 1'b0;
      case (req)
         2'b01:   sel = 1'b0;
         2'b10:   sel = 1'b1;
         2'b11:   sel = ~last;
         default: sel = 1'b0;
      endcase
   end

endmodule

// File: rtl/sd_port_arbiter.sv
// Two-port arbiter and sector transaction sequencer in front of one SD SPI
// controller. Optional watchdog: define SD_ARB_TIMEOUT_EN to abort stuck
// transactions after TIMEOUT_CYCLES and pulse sd_reset to the controller.
module sd_port_arbiter
   import sd_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 2_500_000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        p0_req,
   input  logic        p0_we,
   input  logic [31:0] p0_addr,
   output logic        p0_gnt,
   output logic        p0_done,
   output logic        p0_err,
   output logic [7:0]  p0_rdata,
   output logic        p0_rvalid,
   input  logic [7:0]  p0_wdata,
   output logic        p0_wready,
   input  logic        p1_req,
   input  logic        p1_we,
   input  logic [31:0] p1_addr,
   output logic        p1_gnt,
   output logic        p1_done,
   output logic        p1_err,
   output logic [7:0]  p1_rdata,
   output logic        p1_rvalid,
   input  logic [7:0]  p1_wdata,
   output logic        p1_wready,
   output logic        sd_rd,
   output logic        sd_wr,
   output logic [31:0] sd_address,
   output logic [7:0]  sd_din,
   input  logic [7:0]  sd_dout,
   input  logic        sd_byte_available,
   input  logic        sd_ready_for_next_byte,
   input  logic        sd_ready,
   output logic        sd_reset
);

   sd_arb_state_t state, state_next;
   logic          sel, sel_next;
   logic          we_q, we_next;
   logic          last, last_next;
   logic          err_q, err_next;
   logic [31:0]   addr_q, addr_next;
   logic [9:0]    byte_cnt, cnt_next, cnt_step;
   logic          pick_valid, pick_sel;
   logic [31:0]   pick_addr;
   logic          pick_we;
   logic          granted;

`ifdef SD_ARB_TIMEOUT_EN
   localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
   logic [31:0]   tmo_cnt, tmo_cnt_next;
   logic          tmo_hit, tmo_hit_next;
`endif

   sd_rr_pick u_pick (
      .req   ({p1_req, p0_req}),
      .last  (last),
      .valid (pick_valid),
      .sel   (pick_sel)
   );

   assign pick_addr = pick_sel ? p1_addr : p0_addr;
   assign pick_we   = pick_sel ? p1_we   : p0_we;

   // State and transaction registers; reset aborts any transaction silently.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         sel      <= 1'b0;
         we_q     <= 1'b0;
         last     <= 1'b1;
         err_q    <= 1'b0;
         addr_q   <= 32'd0;
         byte_cnt <= 10'd0;
      end else begin
         state    <= state_next;
         sel      <= sel_next;
         we_q     <= we_next;
         last     <= last_next;
         err_q    <= err_next;
         addr_q   <= addr_next;
         byte_cnt <= cnt_next;
      end
   end

`ifdef SD_ARB_TIMEOUT_EN
   // Watchdog counter and the flag that turns the DONE cycle into a controller reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         tmo_cnt <= 32'd0;
         tmo_hit <= 1'b0;
      end else begin
         tmo_cnt <= tmo_cnt_next;
         tmo_hit <= tmo_hit_next;
      end
   end
`endif

   // Next-state logic: arbitrate in IDLE, strobe until the controller goes busy,
   // count read bytes until it is ready again, then report for one cycle.
   always_comb begin
      state_next = state;
      sel_next   = sel;
      we_next    = we_q;
      last_next  = last;
      err_next   = err_q;
      addr_next  = addr_q;
      cnt_next   = byte_cnt;
      cnt_step   = byte_cnt + {9'd0, sd_byte_available};
`ifdef SD_ARB_TIMEOUT_EN
      tmo_cnt_next = tmo_cnt;
      tmo_hit_next = tmo_hit;
`endif
      case (state)
         IDLE: begin
            if (sd_ready && pick_valid) begin
               sel_next = pick_sel;
               if (!sd_is_aligned(pick_addr)) begin
                  err_next   = 1'b1;
                  state_next = DONE;
               end else begin
                  we_next    = pick_we;
                  addr_next  = pick_addr;
                  cnt_next   = 10'd0;
                  err_next   = 1'b0;
                  state_next = ISSUE;
`ifdef SD_ARB_TIMEOUT_EN
                  tmo_cnt_next = 32'd0;
`endif
               end
            end
         end
         ISSUE: begin
            if (!sd_ready) state_next = BUSY;
         end
         BUSY: begin
            cnt_next = cnt_step;
            if (sd_ready) begin
               err_next   = ~we_q & (cnt_step != 10'(SD_SECTOR_BYTES));
               state_next = DONE;
            end
         end
         DONE: begin
            last_next  = sel;
            state_next = IDLE;
`ifdef SD_ARB_TIMEOUT_EN
            tmo_hit_next = 1'b0;
`endif
         end
         default: state_next = IDLE;
      endcase
`ifdef SD_ARB_TIMEOUT_EN
      if (state == ISSUE || state == BUSY) begin
         if (tmo_cnt == TIMEOUT_LAST) begin
            state_next   = DONE;
            err_next     = 1'b1;
            tmo_hit_next = 1'b1;
         end else begin
            tmo_cnt_next = tmo_cnt + 32'd1;
         end
      end
`endif
   end

   assign granted    = (state == ISSUE) || (state == BUSY);
   assign p0_gnt     = granted & ~sel;
   assign p1_gnt     = granted & sel;
   assign p0_done    = (state == DONE) & ~sel;
   assign p1_done    = (state == DONE) & sel;
   assign p0_err     = p0_done & err_q;
   assign p1_err     = p1_done & err_q;
   assign sd_rd      = (state == ISSUE) & ~we_q;
   assign sd_wr      = (state == ISSUE) & we_q;
   assign sd_address = addr_q;
   assign sd_din     = p0_gnt ? p0_wdata : (p1_gnt ? p1_wdata : 8'hFF);
   assign p0_rdata   = sd_dout;
   assign p1_rdata   = sd_dout;
   assign p0_rvalid  = sd_byte_available & p0_gnt & ~p0_we;
   assign p1_rvalid  = sd_byte_available & p1_gnt & ~p1_we;
   assign p0_wready  = sd_ready_for_next_byte & p0_gnt & p0_we;
   assign p1_wready  = sd_ready_for_next_byte & p1_gnt & p1_we;

`ifdef SD_ARB_TIMEOUT_EN
   assign sd_reset = (state == DONE) & tmo_hit;
`else
   assign sd_reset = 1'b0;
`endif

endmodule
